// File: rtl/adc_spi_capture_14bit_if.sv
// Signal bundle between the 14-bit ADC SPI capture block and its neighbours:
// ADC pins on one side, the captured-sample stream on the other.
interface adc_spi_capture_14bit_if;
    logic        en;
    logic        adc_sdo;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [13:0] data_out;
    logic        data_valid;
    logic        lead_err;
    logic        busy;

    modport master (
        input  en, adc_sdo,
        output adc_cs_n, adc_sclk, data_out, data_valid, lead_err, busy
    );

    modport slave (
        output en, adc_sdo,
        input  adc_cs_n, adc_sclk, data_out, data_valid, lead_err, busy
    );
endinterface

// File: rtl/adc_spi_capture_14bit.sv
// SPI master for a 14-bit serial ADC: 16-clock frames (2 leading zeros + 14 data bits,
// MSB first), holding the last sample and pulsing data_valid on each new capture.
module adc_spi_capture_14bit #(
    parameter int CLK_DIV  = 4,
    parameter int CONV_GAP = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adc_spi_capture_14bit_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int DIV_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int GAP_W = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CONV_GAP - 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic             half_hi;
    logic [15:0]      shift;
    logic             cs_n;
    logic             sclk;
    logic [13:0]      data;
    logic             valid;
    logic             lerr;
    logic             busy_r;
    logic             div_done;

    assign div_done = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            half_hi <= 1'b0;
            shift   <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b1;
            data    <= '0;
            valid   <= 1'b0;
            lerr    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid <= 1'b0;
            lerr  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state   <= S_SETUP;
                        cs_n    <= 1'b0;
                        busy_r  <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (div_done) begin
                        state   <= S_SHIFT;
                        sclk    <= 1'b0;
                        half_hi <= 1'b0;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!half_hi) begin
                            // Sample on the same edge that raises SCLK; ADC changed SDO at the fall.
                            sclk    <= 1'b1;
                            half_hi <= 1'b1;
                            shift   <= {shift[14:0], bus.adc_sdo};
                        end else if (bit_cnt == 4'd15) begin
                            state   <= S_GAP;
                            cs_n    <= 1'b1;
                            data    <= shift[13:0];
                            valid   <= 1'b1;
                            lerr    <= shift[15] | shift[14];
                            gap_cnt <= '0;
                        end else begin
                            sclk    <= 1'b0;
                            half_hi <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // The data_valid cycle is the first of the CONV_GAP cycles.
                    if (gap_cnt == GAP_LAST) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cs_n   <= 1'b1;
                    sclk   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_cs_n   = cs_n;
    assign bus.adc_sclk   = sclk;
    assign bus.data_out   = data;
    assign bus.data_valid = valid;
    assign bus.lead_err   = lerr;
    assign bus.busy       = busy_r;
endmodule

// File: doc/adc_spi_capture_14bit.md
Name: adc_spi_capture_14bit

Overview:
- SPI master front end for a 14-bit serial ADC (16-clock frame: 2 leading zeros, then 14 data bits, MSB first).
- Sits directly upstream of the 8-sample averaging stage.
- DATA_OUT holds the latest conversion between updates, so a downstream stage clocked every CLK sees a stable sample.
- DATA_VALID marks each new sample.

Parameters:
- CLK_DIV, 4: CLK cycles per SCLK half-period; legal range 1 or more.
- CONV_GAP, 16: minimum CLK cycles with ADC_CS_N high between frames, including the DATA_VALID cycle; legal range 1 or more.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- EN  in  1  conversion enable; level-sensitive, sampled only in IDLE.
- ADC_SDO  in  1  serial data from ADC.
- ADC_CS_N  out  1  ADC chip select, active low; registered.
- ADC_SCLK  out  1  serial clock; idles high; registered.
- DATA_OUT  out  14  last captured sample; holds until next capture.
- DATA_VALID  out  1  one-CLK pulse when DATA_OUT updates.
- LEAD_ERR  out  1  one-CLK pulse with DATA_VALID if either leading bit was 1.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST_N low at a CLK edge), takes effect on that edge regardless of state:
  - State goes to IDLE.
  - ADC_CS_N=1, ADC_SCLK=1, DATA_OUT=0, DATA_VALID=0, LEAD_ERR=0, BUSY=0.
  - Shift register, bit counter and divider counter cleared.
- Reset mid-frame: frame is abandoned; no DATA_VALID and no partial DATA_OUT update.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - ADC_CS_N=1, ADC_SCLK=1.
  - At an edge with EN=1: go to SETUP and drive ADC_CS_N=0 from that edge.
- SETUP:
  - Lasts CLK_DIV cycles with ADC_CS_N=0, ADC_SCLK=1.
  - Then go to SHIFT.
- SHIFT: 16 bit periods, each 2*CLK_DIV cycles.
  - ADC_SCLK is low for the first CLK_DIV cycles (ADC updates SDO on the falling edge), then high for CLK_DIV cycles.
  - ADC_SDO is sampled into the shift register on the CLK edge that drives ADC_SCLK 0->1.
  - Bits are shifted in MSB first; 16 samples are taken per frame.
  - After the 16th bit's high half, go to GAP.
- Frame end (the edge entering GAP):
  - ADC_CS_N=1.
  - DATA_OUT <= shift[13:0].
  - DATA_VALID=1 for exactly that one cycle.
  - LEAD_ERR = shift[15] | shift[14], pulsed in the same cycle.
- CS_N low duration per frame: exactly CLK_DIV*33 cycles (132 at default).
- GAP:
  - ADC_CS_N=1 for CONV_GAP cycles, counting the DATA_VALID cycle.
  - Then go to IDLE.
- Continuous EN=1: frame period is CLK_DIV*33 + CONV_GAP + 1 cycles (149 at default; the extra cycle is the IDLE sampling cycle).
- EN deasserted during SETUP, SHIFT or GAP: the current frame completes normally and no new frame starts.
- EN reasserted later: the frame starts at the next IDLE edge with EN=1.
- Bit counter wrap-around is never observable: the counter resets at SETUP entry.
- Divider counter counts 0..CLK_DIV-1.
- No arithmetic on data; DATA_OUT is unsigned 14-bit, range 0 to 0x3FFF.
- DATA_OUT and DATA_VALID are registered; nothing combinational reaches an output.

Test Plan:
- Reset then hold: RST_N=0 for 3 cycles, EN=1 -> ADC_CS_N=1, ADC_SCLK=1, DATA_OUT=0, DATA_VALID=0, BUSY=0 throughout. After RST_N=1, ADC_CS_N falls on the first edge.
- Single capture: ADC model frames 0x2A5C as 00_10101001011100, EN=1 for one IDLE edge, defaults -> ADC_CS_N low exactly 132 cycles, exactly 16 ADC_SCLK rising edges, DATA_OUT=0x2A5C with DATA_VALID high for 1 cycle, LEAD_ERR=0.
- Continuous stream: model returns 0x0000, 0x3FFF, 0x1234 in sequence with EN held high -> DATA_VALID pulses spaced exactly 149 cycles apart, DATA_OUT sequence 0x0000, 0x3FFF, 0x1234. DATA_OUT is held constant between pulses.
- Leading-bit error: model drives frame 0xC001 (leading bits 11) -> DATA_OUT=0x0001, DATA_VALID=1 and LEAD_ERR=1 in the same cycle.
- EN drop mid-frame: EN=0 on the 40th cycle of SHIFT -> frame completes with a valid capture, then ADC_CS_N stays high and BUSY falls CONV_GAP cycles after DATA_VALID.
- Reset mid-SHIFT: RST_N=0 at bit 8, previous DATA_OUT=0x1234 -> on the next edge ADC_CS_N=1, ADC_SCLK=1 and DATA_OUT=0, with no DATA_VALID. Repeat with CLK_DIV=1, CONV_GAP=1 -> CS_N low for 33 cycles and period 35 cycles.
